// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default parameters for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 4096;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search from ptr upward, wrapping to 0
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);
  logic [IDX_W-1:0] w_idx;
  // Scan from the farthest offset down so the closest hit to ptr wins last
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbitration of byte requesters onto one UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(TIMEOUT_CYC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      timeout_err
);
  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_grant_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_tx_start;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_timeout_err;
  logic [IDX_W-1:0]   w_winner;
  logic               w_valid;
  logic [DATA_W-1:0]  w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_cnt         <= '0;
      r_gnt         <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_gnt         <= '0;
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: if (w_valid && !tx_busy) begin
          r_state    <= LAUNCH;
          r_grant_id <= w_winner;
          r_tx_data  <= w_bytes[w_winner];
          r_gnt      <= NUM_REQ'(1) << w_winner;
          r_tx_start <= 1'b1;
        end
        LAUNCH: begin
          r_state <= WAIT_DONE;
          r_ptr   <= r_grant_id == IDX_W'(NUM_REQ - 1) ? '0 : r_grant_id + 1'b1;
          r_cnt   <= '0;
        end
        WAIT_DONE: begin
          // Timeout fires as the counter steps onto TIMEOUT_CYC-1; tx_done on that edge wins
          if (tx_done) r_state <= IDLE;
          else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(TIMEOUT_CYC - 2)) begin
              r_state       <= IDLE;
              r_timeout_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, latency, timeout and reset abort
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [7:0]  bytes [4] = '{8'h3C, 8'h5A, 8'hA5, 8'hC3};
  int          n_checks = 0;
  int          n_fail = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_start"}, 32'(tx_start), 0);
    check({tag, "_terr"}, 32'(timeout_err), 0);
  endtask

  task automatic expect_launch(input int id);
    check("launch_start", 32'(tx_start), 1);
    check("launch_gnt", 32'(gnt), 32'(1) << id);
    check("launch_id", 32'(grant_id), 32'(id));
    check("launch_data", 32'(tx_data), 32'(bytes[id]));
  endtask

  // Finish a frame with tx_done lat cycles after tx_start; ends on the earliest relaunch cycle
  task automatic complete(input int lat, input int id);
    tick();
    check("pulse_start", 32'(tx_start), 0);
    check("pulse_gnt", 32'(gnt), 0);
    repeat (lat - 1) tick();
    check("data_hold", 32'(tx_data), 32'(bytes[id]));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("gap_start", 32'(tx_start), 0);
    tick();
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic seen_terr;
    reset = 1'b1;
    req = 4'b1111;
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    tx_busy = 1'b0;
    tx_done = 1'b0;
    repeat (3) tick();
    expect_quiet("rst");
    check("rst_data", 32'(tx_data), 0);
    check("rst_id", 32'(grant_id), 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_launch(order[i]);
      if (i == 4) req = 4'b0000;
      complete(10, order[i]);
    end
    check("drained_start", 32'(tx_start), 0);
    reset = 1'b1;
    req = 4'b1000;
    tick();
    reset = 1'b0;
    tick();
    expect_launch(3);
    complete(10, 3);
    expect_launch(3);
    req = 4'b1001;
    complete(10, 3);
    expect_launch(0);
    req = 4'b0100;
    repeat (15) tick();
    check("pre_timeout", 32'(timeout_err), 0);
    tick();
    check("timeout", 32'(timeout_err), 1);
    check("timeout_start", 32'(tx_start), 0);
    tick();
    check("timeout_pulse", 32'(timeout_err), 0);
    expect_launch(2);
    repeat (15) tick();
    tx_done = 1'b1;
    req = 4'b0000;
    tick();
    tx_done = 1'b0;
    check("done_beats_timeout", 32'(timeout_err), 0);
    req = 4'b0010;
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busy_hold", 32'(tx_start), 0);
    end
    tx_busy = 1'b0;
    tick();
    expect_launch(1);
    repeat (3) tick();
    reset = 1'b1;
    req = 4'b0000;
    tick();
    reset = 1'b0;
    expect_quiet("abort");
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("late_done_start", 32'(tx_start), 0);
    seen_terr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_terr |= timeout_err | tx_start;
    end
    check("abort_silent", 32'(seen_terr), 0);
    req = 4'b1111;
    tick();
    expect_launch(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter.
REQ-002 The block SHALL have parameter DATA_W, default 8: byte width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096: maximum clk cycles to wait for tx_done after a launch.
REQ-004 clk  input  1  single system clock; all logic rising-edge triggered.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester level request; bit i high means req_data slice i is valid.
REQ-007 req_data  input  NUM_REQ*DATA_W  packed bytes; slice i is bits [i*DATA_W +: DATA_W].
REQ-008 gnt  output  NUM_REQ  one-hot, one-cycle pulse; the requester's byte was taken.
REQ-009 tx_start  output  1  one-cycle launch pulse to the transmitter.
REQ-010 tx_data  output  DATA_W  byte to the transmitter; held stable from the tx_start cycle until tx_done.
REQ-011 tx_busy  input  1  the transmitter is shifting a frame.
REQ-012 tx_done  input  1  one-cycle pulse at the end of the stop bit.
REQ-013 grant_id  output  $clog2(NUM_REQ)  index of the current or last winner.
REQ-014 timeout_err  output  1  one-cycle pulse when a launched frame never completes.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH and WAIT_DONE.
REQ-016 IDLE SHALL go to LAUNCH on the edge where req!=0 and tx_busy==0; otherwise it SHALL stay in IDLE.
REQ-017 On the IDLE->LAUNCH edge, the block SHALL pick the winner round-robin, searching from priority pointer ptr upward and wrapping NUM_REQ-1 to 0; it SHALL register grant_id, tx_data=req_data[winner] and gnt=one-hot(winner).
REQ-018 In LAUNCH, which lasts exactly one cycle, tx_start and gnt SHALL both be high; the next state SHALL be WAIT_DONE.
REQ-019 Latency SHALL be exactly one cycle from the request-sampling edge to tx_start/gnt high.
REQ-020 On the LAUNCH edge, ptr SHALL be set to (winner+1) mod NUM_REQ.
REQ-021 WAIT_DONE SHALL go to IDLE on tx_done; the earliest next tx_start SHALL therefore be 2 cycles after tx_done.
REQ-022 In WAIT_DONE, a wait counter SHALL increment each cycle; if it reaches TIMEOUT_CYC-1 without tx_done, the block SHALL pulse timeout_err and go to IDLE.
REQ-023 The wait counter SHALL clear on entry to WAIT_DONE, with width $clog2(TIMEOUT_CYC).
REQ-024 tx_done in IDLE or LAUNCH SHALL be ignored; tx_done on the timeout cycle SHALL take precedence, so no timeout_err is raised.
REQ-025 A req bit dropped before being sampled in IDLE SHALL never be granted; req is not sampled outside IDLE.
REQ-026 gnt, tx_start and timeout_err SHALL never be high in the same cycle as reset or outside the states defined above.

Reset
REQ-027 When reset is high at a clk edge, the next state SHALL be: state=IDLE, ptr=0, wait counter=0, gnt=0, tx_start=0, tx_data=0, grant_id=0, timeout_err=0.
REQ-028 Reset asserted in LAUNCH or WAIT_DONE SHALL abort the transaction; no further gnt or timeout_err SHALL occur for it.
REQ-029 Reset SHALL take priority over every other condition.

Structure
REQ-030 The state enum and default parameter constants SHALL live in shared package uart_pkg.
REQ-031 The round-robin pick SHALL be a combinational sub-module rr_picker with inputs req and ptr, and outputs winner index and a valid flag.
REQ-032 The remaining logic (FSM, data register, timeout counter) SHALL live in uart_tx_arbiter.

Verification
REQ-033 Reset with req=4'b1111 held SHALL produce all outputs 0; on the first cycle after reset, tx_start rises with grant_id=0 and gnt=4'b0001.
REQ-034 req=4'b1111, with tx_done returned 10 cycles after each tx_start, SHALL yield grant order 0,1,2,3,0, each tx_data matching its slice (e.g. 8'hA5 for slice 2).
REQ-035 Only req[3] held, ptr=0 SHALL grant 3 repeatedly, with ptr wrapping to 0 after each grant.
REQ-036 With TIMEOUT_CYC=16 and tx_done never returned, timeout_err SHALL pulse 16 cycles after tx_start, then the next grant SHALL proceed.
REQ-037 tx_busy=1 held in IDLE with req=4'b0010 SHALL produce no tx_start; after tx_busy falls, tx_start SHALL rise exactly one cycle later.
REQ-038 Reset asserted 3 cycles into WAIT_DONE SHALL return the block to IDLE; a later tx_done SHALL be ignored, and arbitration SHALL restart from ptr=0.
